seg7_display_ctrl: RTL and testbench

- Parametrised multi-digit seven-segment display controller driving the board HEX outputs from the top wrapper.
- Loads a binary value and shows it in hex or decimal (iterative double-dabble converter).
- Supports leading-zero blanking, per-digit blinking and an overflow indication.
- Supersedes the combinational per-digit decoder; all HEX pins are fed from this block.

---
 rtl/seg7_pkg.sv | 59 +++++
 rtl/seg7_display_ctrl_glyph.sv | 17 +
 rtl/seg7_display_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_seg7_display_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Brief    : Shared FSM state type, active-high glyph patterns (gfedcba) and
//            the nibble-to-glyph lookup used by the seven-segment controller.
// Revision : 1.0
// ============================================================================
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] glyph(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_display_ctrl_glyph.sv
`default_nettype none
// ============================================================================
// Module   : seg7_glyph
// Brief    : Combinational 4-bit to active-high 7-segment (gfedcba) decoder.
// Revision : 1.0
// ============================================================================
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = glyph(i_nibble);

endmodule
`default_nettype wire

// File: rtl/seg7_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_display_ctrl
// Brief    : Multi-digit seven-segment controller: hex or double-dabble decimal
//            display with leading-zero blanking, per-digit blink and overflow.
// Revision : 1.0
// ============================================================================
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DATA_W     = 27,
    parameter int BLINK_HALF = 25_000_000,
    parameter bit ACTIVE_LOW = 1'b1
)(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic [DATA_W-1:0]       i_value,
    input  logic                    i_mode,
    input  logic                    i_blank_lz,
    input  logic [NUM_DIGITS-1:0]   i_blink_mask,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_overflow,
    output logic [7*NUM_DIGITS-1:0] o_hex
);

    localparam int c_DIG_W = 4 * NUM_DIGITS;
    localparam int c_SEG_W = 7 * NUM_DIGITS;
    localparam int c_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int c_BLK_W = $clog2(BLINK_HALF);
    localparam logic [c_SEG_W-1:0] c_POL = {c_SEG_W{ACTIVE_LOW}};

    state_t               r_state;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_overflow;
    logic [DATA_W-1:0]    r_bin;
    logic [c_DIG_W-1:0]   r_bcd;
    logic                 r_bcd_ovf;
    logic                 r_blank_lz;
    logic [c_CNT_W-1:0]   r_shift_cnt;
    logic [c_SEG_W-1:0]   r_disp;
    logic [c_SEG_W-1:0]   r_hex;
    logic [c_BLK_W-1:0]   r_blink_cnt;
    logic                 r_blink_off;

    logic [c_DIG_W-1:0]   w_bcd_adj;
    logic [c_DIG_W-1:0]   w_bcd_next;
    logic                 w_bcd_carry;
    logic                 w_last_step;
    logic                 w_hex_load;
    logic                 w_commit;
    logic [63:0]          w_value_ext;
    logic                 w_hex_ovf;
    logic [c_DIG_W-1:0]   w_src;
    logic                 w_new_ovf;
    logic                 w_new_lz;
    logic                 w_lead_seen;
    logic [6:0]           w_seg [NUM_DIGITS];
    logic [c_SEG_W-1:0]   w_new_disp;
    logic [c_SEG_W-1:0]   w_show;
    logic [c_SEG_W-1:0]   w_masked;

    // Double-dabble step: add 3 to every digit >= 5, then shift in the value MSB.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    assign w_bcd_carry = w_bcd_adj[c_DIG_W-1];
    assign w_bcd_next  = {w_bcd_adj[c_DIG_W-2:0], r_bin[DATA_W-1]};

    assign w_last_step = (r_state == CONVERT) && (r_shift_cnt == c_CNT_W'(DATA_W - 1));
    assign w_hex_load  = (r_state == IDLE) && i_load && !i_mode;
    assign w_commit    = w_hex_load || w_last_step;

    assign w_value_ext = 64'(i_value);
    assign w_hex_ovf   = (w_value_ext >> c_DIG_W) != 64'd0;

    // The display is written on the edge that enters UPDATE, so the new value
    // is visible in the same cycle as o_done.
    assign w_src     = (r_state == IDLE) ? w_value_ext[c_DIG_W-1:0] : w_bcd_next;
    assign w_new_ovf = (r_state == IDLE) ? w_hex_ovf : (r_bcd_ovf | w_bcd_carry);
    assign w_new_lz  = (r_state == IDLE) ? i_blank_lz : r_blank_lz;

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
            seg7_glyph u_glyph (
                .i_nibble (w_src[4*g +: 4]),
                .o_seg    (w_seg[g])
            );
        end
    endgenerate

    always_comb begin
        w_lead_seen = 1'b0;
        w_new_disp  = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (w_src[4*k +: 4] != 4'd0) begin
                w_lead_seen = 1'b1;
            end
            if (w_new_ovf) begin
                w_new_disp[7*k +: 7] = SEG_DASH;
            end else if (w_lead_seen || (k == 0) || !w_new_lz) begin
                w_new_disp[7*k +: 7] = w_seg[k];
            end else begin
                w_new_disp[7*k +: 7] = SEG_BLANK;
            end
        end
    end

    always_comb begin
        w_show   = w_commit ? w_new_disp : r_disp;
        w_masked = w_show;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_blink_off && i_blink_mask[k]) begin
                w_masked[7*k +: 7] = SEG_BLANK;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_bcd_ovf   <= 1'b0;
            r_blank_lz  <= 1'b0;
            r_shift_cnt <= '0;
            r_disp      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_load) begin
                        r_blank_lz <= i_blank_lz;
                        r_busy     <= 1'b1;
                        if (i_mode) begin
                            r_state     <= CONVERT;
                            r_bin       <= i_value;
                            r_bcd       <= '0;
                            r_bcd_ovf   <= 1'b0;
                            r_shift_cnt <= '0;
                        end else begin
                            r_state <= UPDATE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                CONVERT: begin
                    r_bcd       <= w_bcd_next;
                    r_bin       <= r_bin << 1;
                    r_bcd_ovf   <= r_bcd_ovf | w_bcd_carry;
                    r_shift_cnt <= r_shift_cnt + c_CNT_W'(1);
                    if (w_last_step) begin
                        r_state <= UPDATE;
                        r_done  <= 1'b1;
                    end
                end
                UPDATE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            if (w_commit) begin
                r_disp     <= w_new_disp;
                r_overflow <= w_new_ovf;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (r_blink_cnt == c_BLK_W'(BLINK_HALF - 1)) begin
            r_blink_cnt <= '0;
            r_blink_off <= ~r_blink_off;
        end else begin
            r_blink_cnt <= r_blink_cnt + c_BLK_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hex <= c_POL;
        end else begin
            r_hex <= w_masked ^ c_POL;
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_overflow = r_overflow;
    assign o_hex      = r_hex;

endmodule
`default_nettype wire

// File: tb/tb_seg7_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_display_ctrl
// Brief    : Self-checking bench for seg7_display_ctrl against an arithmetic
//            model of the displayed digits, blanking, overflow and blink phase.
// Revision : 1.0
// ============================================================================
module tb_seg7_display_ctrl;

    localparam int ND = 8;
    localparam int DW = 27;
    localparam int BH = 4;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_load = 1'b0;
    logic [DW-1:0]     i_value = '0;
    logic              i_mode = 1'b0;
    logic              i_blank_lz = 1'b0;
    logic [ND-1:0]     i_blink_mask = '0;
    logic              o_busy;
    logic              o_done;
    logic              o_overflow;
    logic [7*ND-1:0]   o_hex;

    int                checks = 0;
    int                errors = 0;
    int                edges = 0;
    logic [ND-1:0]     mask_q = '0;
    logic [7*ND-1:0]   exp_disp = '0;
    logic              exp_ovf = 1'b0;

    logic [6:0] gly [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_display_ctrl #(
        .NUM_DIGITS (ND),
        .DATA_W     (DW),
        .BLINK_HALF (BH),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_load       (i_load),
        .i_value      (i_value),
        .i_mode       (i_mode),
        .i_blank_lz   (i_blank_lz),
        .i_blink_mask (i_blink_mask),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_overflow   (o_overflow),
        .o_hex        (o_hex)
    );

    always #5 i_clk = ~i_clk;

    // Non-reset edges since reset, and the blink mask the DUT saw at the last edge.
    always @(posedge i_clk) begin
        if (i_rst) edges <= 0;
        else       edges <= edges + 1;
        mask_q <= i_blink_mask;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
            $error("check %s failed", tag);
        end
    endtask

    function automatic logic [7*ND-1:0] model_disp(input logic [DW-1:0] v, input logic m,
                                                   input logic lz, output logic ovf);
        longint       x = longint'(v);
        longint       p = 1;
        int           d [ND];
        int           msd = 0;
        logic [7*ND-1:0] r = '0;
        ovf = m ? (x >= 64'd100000000) : ((x >> (4*ND)) != 0);
        for (int k = 0; k < ND; k++) begin
            d[k] = m ? int'((x / p) % 10) : int'((x >> (4*k)) & 15);
            p = p * 10;
            if (d[k] != 0) msd = k;
        end
        for (int k = 0; k < ND; k++) begin
            if (ovf)                  r[7*k +: 7] = 7'h40;
            else if (!lz || k <= msd) r[7*k +: 7] = gly[d[k]];
            else                      r[7*k +: 7] = 7'h00;
        end
        return r;
    endfunction

    function automatic logic [7*ND-1:0] exp_hex(input logic [7*ND-1:0] disp, input int n,
                                                input logic [ND-1:0] m);
        logic [7*ND-1:0] r = disp;
        bit off = (n >= 1) && ((((n - 1) / BH) % 2) == 1);
        for (int k = 0; k < ND; k++) begin
            if (off && m[k]) r[7*k +: 7] = 7'h00;
        end
        return ~r;
    endfunction

    // One load in cycle t; disturb_at>0 injects a second load (or a reset) at t+disturb_at.
    task automatic run_load(input logic [DW-1:0] v, input logic m, input logic lz,
                            input int disturb_at, input logic disturb_rst);
        logic [7*ND-1:0] d;
        logic            ov;
        int              exp_lat;
        int              busy_cnt = 0;
        int              done_cnt = 0;
        int              done_lat = 0;
        d       = model_disp(v, m, lz, ov);
        exp_lat = m ? DW + 1 : 1;
        @(posedge i_clk); #1;
        i_value = v; i_mode = m; i_blank_lz = lz; i_load = 1'b1;
        for (int c = 1; c <= DW + 6; c++) begin
            @(posedge i_clk); #1;
            i_load = 1'b0;
            i_rst  = 1'b0;
            if (c == disturb_at) begin
                if (disturb_rst) i_rst = 1'b1;
                else begin i_load = 1'b1; i_value = DW'(777); i_mode = 1'b1; end
            end
            @(negedge i_clk);
            if (o_busy) busy_cnt++;
            if (!disturb_rst && exp_lat > 1 && c == exp_lat - 1)
                chk("hex_old_held", 64'(o_hex), 64'(exp_hex(exp_disp, edges, mask_q)));
            if (disturb_rst && c == disturb_at + 1) begin
                chk("rst_mid_busy", 64'(o_busy), 64'(0));
                chk("rst_mid_hex", 64'(o_hex), 64'({7*ND{1'b1}}));
            end
            if (o_done) begin
                done_cnt++;
                done_lat = c;
                chk("hex_at_done", 64'(o_hex), 64'(exp_hex(d, edges, mask_q)));
                chk("ovf_at_done", 64'(o_overflow), 64'(ov));
            end
        end
        if (disturb_rst) begin
            chk("rst_no_done", 64'(done_cnt), 64'(0));
            exp_disp = '0;
            exp_ovf  = 1'b0;
        end else begin
            chk("done_count", 64'(done_cnt), 64'(1));
            chk("done_latency", 64'(done_lat), 64'(exp_lat));
            chk("busy_cycles", 64'(busy_cnt), 64'(exp_lat));
            exp_disp = d;
            exp_ovf  = ov;
        end
        chk("hex_hold", 64'(o_hex), 64'(exp_hex(exp_disp, edges, mask_q)));
        chk("ovf_hold", 64'(o_overflow), 64'(exp_ovf));
    endtask

    initial begin
        logic [DW-1:0] rv;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        chk("reset_hex", 64'(o_hex), 64'({7*ND{1'b1}}));
        chk("reset_busy", 64'(o_busy), 64'(0));
        chk("reset_done", 64'(o_done), 64'(0));
        chk("reset_ovf", 64'(o_overflow), 64'(0));

        run_load(DW'(27'h1234ABC), 1'b0, 1'b0, 0, 1'b0);
        chk("hex_digit0_C", 64'(o_hex[6:0]), 64'(7'h46));
        chk("hex_digit7_0", 64'(o_hex[55:49]), 64'(7'h40));

        @(posedge i_clk); #1 i_blink_mask = 8'h01;
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clk);
            chk("blink_hex", 64'(o_hex), 64'(exp_hex(exp_disp, edges, mask_q)));
        end
        @(posedge i_clk); #1 i_blink_mask = '0;
        @(negedge i_clk);

        run_load(DW'(12345), 1'b1, 1'b1, 0, 1'b0);
        chk("dec_digit5_blank", 64'(o_hex[41:35]), 64'(7'h7F));
        run_load(DW'(0), 1'b1, 1'b1, 0, 1'b0);
        chk("zero_digit0", 64'(o_hex[6:0]), 64'(7'h40));
        chk("zero_digit1_blank", 64'(o_hex[13:7]), 64'(7'h7F));
        run_load(DW'(100000000), 1'b1, 1'b0, 0, 1'b0);
        chk("ovf_dash", 64'(o_hex[6:0]), 64'(7'h3F));
        run_load(DW'(99999999), 1'b1, 1'b0, 0, 1'b0);
        run_load(DW'(42), 1'b1, 1'b0, 5, 1'b0);
        run_load(DW'(555), 1'b1, 1'b0, 10, 1'b1);

        for (int i = 0; i < 12; i++) begin
            case ($urandom % 4)
                0:       rv = DW'($urandom);
                1:       rv = DW'($urandom % 1000);
                2:       rv = DW'(99999990 + ($urandom % 20));
                default: rv = '0;
            endcase
            run_load(rv, 1'($urandom), 1'($urandom), 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
